fetch_unit: RTL and testbench

- Instruction-fetch stage of the pipelined RV32I core. Owns the program counter and issues requests on a req/ack instruction-memory port.
- Produces the instruction/PC bundle plus the en/flush controls for the IF/ID pipeline register directly downstream.
- Absorbs ID-stage stalls and EX-stage branch/jump redirects, including redirects that arrive while a memory request is outstanding.

---
 rtl/fetch_unit_if.sv | 46 ++++
 rtl/fetch_unit.sv | 152 +++++++++++++++
 tb/tb_fetch_unit.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: groups the fetch stage's control and bus signals.
//   Control in : i_stall, i_redirect, i_redirect_pc
//   IMEM       : o_imem_req, o_imem_addr (out), i_imem_ack, i_imem_rdata (in)
//   IF/ID      : o_ifid_en, o_ifid_flush, o_ifid_instr, o_ifid_pc, o_ifid_pc4, o_pc (out)
//   FETCH_PERF_EN (macro) adds o_fetch_count / o_wait_count.
// Modport master is the fetch unit. Modport slave is its environment
// (hazard unit, EX stage, instruction memory, IF/ID register).
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            i_stall;
  logic            i_redirect;
  logic [XLEN-1:0] i_redirect_pc;
  logic            o_imem_req;
  logic [XLEN-1:0] o_imem_addr;
  logic            i_imem_ack;
  logic [31:0]     i_imem_rdata;
  logic            o_ifid_en;
  logic            o_ifid_flush;
  logic [31:0]     o_ifid_instr;
  logic [XLEN-1:0] o_ifid_pc;
  logic [XLEN-1:0] o_ifid_pc4;
  logic [XLEN-1:0] o_pc;
`ifdef FETCH_PERF_EN
  logic [31:0]     o_fetch_count;
  logic [31:0]     o_wait_count;
`endif

  modport master (
    input  i_stall, i_redirect, i_redirect_pc, i_imem_ack, i_imem_rdata,
    output o_imem_req, o_imem_addr, o_ifid_en, o_ifid_flush, o_ifid_instr,
           o_ifid_pc, o_ifid_pc4, o_pc
`ifdef FETCH_PERF_EN
    , output o_fetch_count, o_wait_count
`endif
  );

  modport slave (
    output i_stall, i_redirect, i_redirect_pc, i_imem_ack, i_imem_rdata,
    input  o_imem_req, o_imem_addr, o_ifid_en, o_ifid_flush, o_ifid_instr,
           o_ifid_pc, o_ifid_pc4, o_pc
`ifdef FETCH_PERF_EN
    , input o_fetch_count, o_wait_count
`endif
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction-fetch stage. It owns the PC, issues requests
// on the imem req/ack port, and drives the IF/ID register enable/flush plus
// the instruction/PC bundle.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus            : fetch_unit_if.master (control, imem and IF/ID signals)
//   o_dbg_state    : current FSM state (BOOT=0, FETCH=1, HOLD=2, DISCARD=3)
// Optional macro FETCH_PERF_EN adds saturating deliver and wait counters.
//
// Handshakes:
//   imem  - a request is outstanding while o_imem_req=1. o_imem_addr stays
//           stable until the cycle where i_imem_ack=1, which completes the
//           transfer. Ack may come in the same cycle as the request.
//   IF/ID - o_ifid_en=1 means instr/pc/pc4 are valid this cycle and must be
//           loaded. There is no back-pressure: the stall is reported through
//           i_stall, and the fetch unit never asserts en while it is stalled.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0040_0000
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  fetch_unit_if.master  bus,
  output logic [1:0]    o_dbg_state
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [31:0]     hold_q, hold_d;

  logic [XLEN-1:0] redirect_tgt;
  logic [XLEN-1:0] pc_plus4;
  logic            deliver;

  assign redirect_tgt = {bus.i_redirect_pc[XLEN-1:2], 2'b00};
  assign pc_plus4     = pc_q + XLEN'(4);

  // A word is handed to IF/ID either straight from memory or from the hold
  // buffer. Redirect and stall both suppress delivery.
  assign deliver = !bus.i_redirect && !bus.i_stall &&
                   ((state_q == FETCH && bus.i_imem_ack) || state_q == HOLD);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    target_d = target_q;
    hold_d   = hold_q;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        if (bus.i_redirect) begin
          if (bus.i_imem_ack) begin
            pc_d = redirect_tgt;
          end else begin
            target_d = redirect_tgt;
            state_d  = DISCARD;
          end
        end else if (bus.i_imem_ack) begin
          if (bus.i_stall) begin
            // pc_q is frozen while in HOLD, so it also serves as the buffered PC.
            hold_d  = bus.i_imem_rdata;
            state_d = HOLD;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      HOLD: begin
        if (bus.i_redirect) begin
          pc_d    = redirect_tgt;
          state_d = FETCH;
        end else if (!bus.i_stall) begin
          pc_d    = pc_plus4;
          state_d = FETCH;
        end
      end
      DISCARD: begin
        // The old request is still in flight at pc_q. Its data is dropped.
        // A redirect in the ack cycle is younger than the latched one.
        if (bus.i_imem_ack) begin
          pc_d    = bus.i_redirect ? redirect_tgt : target_q;
          state_d = FETCH;
        end else if (bus.i_redirect) begin
          target_d = redirect_tgt;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      target_q <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      hold_q   <= hold_d;
    end
  end

  assign bus.o_imem_req   = (state_q == FETCH) || (state_q == DISCARD);
  assign bus.o_imem_addr  = pc_q;
  assign bus.o_ifid_en    = deliver;
  assign bus.o_ifid_flush = bus.i_redirect || (!bus.i_stall && !deliver) ||
                            (state_q == BOOT);
  assign bus.o_ifid_instr = (state_q == HOLD)  ? hold_q :
                            (state_q == FETCH) ? bus.i_imem_rdata : 32'h0;
  assign bus.o_ifid_pc    = pc_q;
  assign bus.o_ifid_pc4   = pc_plus4;
  assign bus.o_pc         = pc_q;
  assign o_dbg_state      = state_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    if (deliver && fetch_cnt_q != 32'hFFFF_FFFF)
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (bus.o_imem_req && !bus.i_imem_ack && wait_cnt_q != 32'hFFFF_FFFF)
      wait_cnt_d = wait_cnt_q + 32'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fetch_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign bus.o_fetch_count = fetch_cnt_q;
  assign bus.o_wait_count  = wait_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: drives fetch_unit with a directed scenario followed by
// random stall/redirect/ack traffic. The reference model is the program-order
// view of the fetch stream: every delivered word is at the address after the
// previous delivery, or at the most recent redirect target (low bits cleared).
// The memory returns a fixed function of the address.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  fetch_unit_if bus ();

  fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0040_0008) return 32'h00A0_0093;
    return a ^ 32'h5A5A_0000 ^ {a[15:0], a[31:16]} ^ 32'h0000_1357;
  endfunction

  assign bus.i_imem_rdata = mem_word(bus.o_imem_addr);

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic st, input logic rd, input logic [31:0] rpc, input logic ak);
    @(posedge clk);
    #1;
    bus.i_stall       = st;
    bus.i_redirect    = rd;
    bus.i_redirect_pc = rpc;
    bus.i_imem_ack    = ak;
    if (rd) begin
      // A redirect defines the next instruction the stream must deliver.
      exp_q.delete();
      exp_q.push_back({rpc[31:2], 2'b00});
    end
  endtask

  // Directed step: drive, then look at the outputs mid-cycle.
  task automatic dstep(input logic st, input logic rd, input logic [31:0] rpc, input logic ak);
    drive(st, rd, rpc, ak);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ak);
    @(posedge clk);
    #1;
    rst_n             = 1'b0;
    bus.i_stall       = 1'b0;
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = '0;
    bus.i_imem_ack    = ak;
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    @(negedge clk);
    #1;
    check("rst_req",   {31'b0, bus.o_imem_req},   32'h0);
    check("rst_en",    {31'b0, bus.o_ifid_en},    32'h0);
    check("rst_flush", {31'b0, bus.o_ifid_flush}, 32'h1);
    check("rst_instr", bus.o_ifid_instr,          32'h0);
    check("rst_pc",    bus.o_pc,                  RESET_PC);
`ifdef FETCH_PERF_EN
    check("rst_fcnt",  bus.o_fetch_count, 32'h0);
    check("rst_wcnt",  bus.o_wait_count,  32'h0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("boot_req", {31'b0, bus.o_imem_req}, 32'h0);
  endtask

  // ---------------- monitor ----------------
  logic        was_high;
  logic        pend;
  logic [31:0] pend_addr;
  int          idle;
  logic [31:0] m_fetch, m_wait;

  initial begin
    logic        boot;
    logic [31:0] epc;
    was_high  = 1'b0;
    pend      = 1'b0;
    pend_addr = '0;
    idle      = 0;
    m_fetch   = '0;
    m_wait    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        was_high = 1'b0;
        pend     = 1'b0;
        idle     = 0;
        m_fetch  = '0;
        m_wait   = '0;
      end else begin
        boot     = !was_high;
        was_high = 1'b1;
`ifdef FETCH_PERF_EN
        check("fetch_count", bus.o_fetch_count, m_fetch);
        check("wait_count",  bus.o_wait_count,  m_wait);
`endif
        check("flush_rule", {31'b0, bus.o_ifid_flush},
              {31'b0, bus.i_redirect | (!bus.i_stall & !bus.o_ifid_en) | boot});
        if (bus.i_redirect || bus.i_stall || boot)
          check("en_blocked", {31'b0, bus.o_ifid_en}, 32'h0);
        if (pend) begin
          check("req_held",  {31'b0, bus.o_imem_req}, 32'h1);
          check("addr_held", bus.o_imem_addr, pend_addr);
        end
        if (bus.o_ifid_en) begin
          idle = 0;
          m_fetch++;
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL deliver_unexpected: got pc %h expected no delivery", bus.o_ifid_pc);
          end else begin
            epc = exp_q.pop_front();
            check("deliver_pc",    bus.o_ifid_pc,    epc);
            check("deliver_instr", bus.o_ifid_instr, mem_word(epc));
            check("deliver_pc4",   bus.o_ifid_pc4,   epc + 32'd4);
            exp_q.push_back(epc + 32'd4);
          end
        end else begin
          idle++;
          if (idle > 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL progress: got %0d idle cycles expected at most 100", idle);
            idle = 0;
          end
        end
        if (bus.o_imem_req && !bus.i_imem_ack) m_wait++;
        pend      = bus.o_imem_req && !bus.i_imem_ack;
        pend_addr = bus.o_imem_addr;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int since_rst;
    logic st, rd, ak;
    logic [31:0] rpc;
    rst_n             = 1'b0;
    bus.i_stall       = 1'b0;
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = '0;
    bus.i_imem_ack    = 1'b1;

    // Directed walk through the main scenarios.
    do_reset(1'b1);
    dstep(0, 0, 0, 1);
    check("d_addr0", bus.o_imem_addr, 32'h0040_0000);
    check("d_en0",   {31'b0, bus.o_ifid_en}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      dstep(0, 0, 0, 0);
      check("d_wait_addr",  bus.o_imem_addr, 32'h0040_0004);
      check("d_wait_flush", {31'b0, bus.o_ifid_flush}, 32'h1);
    end
    dstep(0, 0, 0, 1);
    check("d_late_pc", bus.o_ifid_pc, 32'h0040_0004);
`ifdef FETCH_PERF_EN
    check("d_wait3", bus.o_wait_count, 32'd3);
`endif
    dstep(1, 0, 0, 1);
    check("d_stall_flush", {31'b0, bus.o_ifid_flush}, 32'h0);
    dstep(1, 0, 0, 0);
    check("d_hold_req",   {31'b0, bus.o_imem_req},   32'h0);
    check("d_hold_flush", {31'b0, bus.o_ifid_flush}, 32'h0);
    dstep(0, 0, 0, 0);
    check("d_hold_instr", bus.o_ifid_instr, 32'h00A0_0093);
    check("d_hold_pc",    bus.o_ifid_pc,    32'h0040_0008);
    dstep(0, 0, 0, 1);
    check("d_after_hold", bus.o_imem_addr, 32'h0040_000C);
    dstep(0, 1, 32'h0040_0102, 0);
    check("d_redir_addr", bus.o_imem_addr, 32'h0040_0010);
    dstep(0, 0, 0, 0);
    check("d_disc_addr", bus.o_imem_addr, 32'h0040_0010);
    dstep(0, 0, 0, 1);
    check("d_disc_drop", {31'b0, bus.o_ifid_en}, 32'h0);
    dstep(0, 0, 0, 1);
    check("d_redir_tgt", bus.o_imem_addr, 32'h0040_0100);
    dstep(1, 0, 0, 1);
    dstep(1, 1, 32'h0040_0200, 0);
    check("d_hr_flush", {31'b0, bus.o_ifid_flush}, 32'h1);
    dstep(0, 0, 0, 1);
    check("d_hr_addr", bus.o_imem_addr, 32'h0040_0200);
    dstep(0, 1, 32'hFFFF_FFFC, 1);
    dstep(0, 0, 0, 1);
    check("d_wrap_pc",  bus.o_ifid_pc,  32'hFFFF_FFFC);
    check("d_wrap_pc4", bus.o_ifid_pc4, 32'h0000_0000);
    dstep(0, 0, 0, 1);
    check("d_wrap_addr", bus.o_imem_addr, 32'h0000_0000);

    // Random traffic, with one reset in the middle.
    since_rst = 10;
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) begin
        do_reset(1'b0);
        since_rst = 0;
      end
      st  = ($urandom_range(0, 3) == 0);
      rd  = (since_rst > 1) && ($urandom_range(0, 15) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                        : $urandom;
      ak  = ($urandom_range(0, 9) < 6);
      drive(st, rd, rpc, ak);
      since_rst++;
    end
    drive(0, 0, 0, 1);
    @(negedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
